// File: rtl/ntt_seq.sv
// rtl/ntt_seq.sv - Read/feed/drain sequencer and FIFO address generator for the NTT core
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      command inputs (start only taken in IDLE; abort wins over everything)
//   busy, done, err   status: busy outside IDLE, one-cycle done / timeout pulses
//   rd_en, rd_addr    polynomial RAM read port (RAM has one cycle of read latency)
//   rd_data           {in[1], in[0]} pair returned by the RAM
//   ntt_in_en, ntt_in core input stream (pair per beat)
//   ntt_out_en, ntt_out core output stream
//   fifo_en           per-stage activity from the core
//   fifom_addr        shared multiplier-FIFO address
//   fifo2_addr        per-stage FIFO2 circular addresses
//   wr_en, wr_addr, wr_data result RAM write port

module ntt_seq #(
    parameter int DATA_WIDTH          = 12,
    parameter int NTT_STAGE_CNT       = 7,
    parameter int MUL_STAGE_CNT       = 4,
    parameter int MUL_STAGE_BITS      = $clog2(MUL_STAGE_CNT),
    parameter int MAX_FIFO2_ADDR_BITS = 5,
    parameter int TIMEOUT             = 1023
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic                                                 abort,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 err,
    output logic                                                 rd_en,
    output logic [NTT_STAGE_CNT-1:0]                             rd_addr,
    input  logic [2*DATA_WIDTH-1:0]                              rd_data,
    output logic                                                 ntt_in_en,
    output logic [1:0][DATA_WIDTH-1:0]                           ntt_in,
    input  logic                                                 ntt_out_en,
    input  logic [1:0][DATA_WIDTH-1:0]                           ntt_out,
    input  logic [NTT_STAGE_CNT-1:0]                             fifo_en,
    output logic [MUL_STAGE_BITS-1:0]                            fifom_addr,
    output logic [NTT_STAGE_CNT-1:0][MAX_FIFO2_ADDR_BITS-1:0]    fifo2_addr,
    output logic                                                 wr_en,
    output logic [NTT_STAGE_CNT-1:0]                             wr_addr,
    output logic [2*DATA_WIDTH-1:0]                              wr_data
);

    localparam int P       = 1 << NTT_STAGE_CNT;
    localparam int CNT_W   = NTT_STAGE_CNT + 1;
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    localparam int FM_SIZE = MUL_STAGE_CNT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              out_cnt;
    logic [WD_W-1:0]               wd_cnt;
    logic [1:0][DATA_WIDTH-1:0]    ntt_in_hold;
    logic                          capture;

    // Beats are only taken while a transform is active and not yet complete.
    assign capture = ntt_out_en && (state == FEED || state == DRAIN) && (out_cnt != CNT_W'(P));

    // The RAM data is forwarded straight through on the beat; between beats the
    // last pair is held so the core never sees a changing bus while idle.
    assign ntt_in = ntt_in_en ? rd_data : ntt_in_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            ntt_in_en   <= 1'b0;
            ntt_in_hold <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            out_cnt     <= '0;
            wd_cnt      <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            // A read already issued still lands on the core, even across abort.
            ntt_in_en <= rd_en;
            if (ntt_in_en) begin
                ntt_in_hold <= rd_data;
            end

            if (abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                rd_en   <= 1'b0;
                rd_addr <= '0;
                wr_addr <= '0;
                out_cnt <= '0;
                wd_cnt  <= '0;
            end else begin
                if (capture) begin
                    wr_en   <= 1'b1;
                    wr_data <= ntt_out;
                    wr_addr <= out_cnt[NTT_STAGE_CNT-1:0];
                    out_cnt <= out_cnt + 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        // Gating on done keeps a start in the completion cycle from
                        // launching a second transform.
                        if (start && !done) begin
                            state   <= FEED;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            out_cnt <= '0;
                            wd_cnt  <= '0;
                        end
                    end
                    FEED: begin
                        if (rd_addr == NTT_STAGE_CNT'(P - 1)) begin
                            rd_en  <= 1'b0;
                            state  <= DRAIN;
                            wd_cnt <= '0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (out_cnt == CNT_W'(P)) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                            out_cnt <= '0;
                        end else if (capture) begin
                            wd_cnt <= '0;
                        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                            out_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shared multiplier FIFO: one slot per multiplier stage beyond the first,
    // stepping whenever any butterfly stage is active.
    generate
        if (FM_SIZE > 1) begin : g_fifom
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifom_addr <= '0;
                end else if (abort) begin
                    fifom_addr <= '0;
                end else if (|fifo_en) begin
                    if (fifom_addr == MUL_STAGE_BITS'(FM_SIZE - 1)) begin
                        fifom_addr <= '0;
                    end else begin
                        fifom_addr <= fifom_addr + 1'b1;
                    end
                end
            end
        end else begin : g_fifom_const
            assign fifom_addr = '0;
        end
    endgenerate

    // Per-stage FIFO2 depth is the gap between the half-butterfly span and the
    // multiplier latency; stages where that depth is trivial keep address 0.
    generate
        for (genvar i = 0; i < NTT_STAGE_CNT; i++) begin : g_fifo2
            localparam int HRS = 1 << (NTT_STAGE_CNT - i - 1);
            localparam int Z   = (HRS > MUL_STAGE_CNT) ? (HRS - MUL_STAGE_CNT - 1)
                                                       : (MUL_STAGE_CNT - HRS - 1);
            if (i == 0 || Z <= 1) begin : g_const
                assign fifo2_addr[i] = '0;
            end else begin : g_cnt
                localparam int ZW = $clog2(Z);
                logic [ZW-1:0] cnt;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cnt <= '0;
                    end else if (abort) begin
                        cnt <= '0;
                    end else if (fifo_en[i]) begin
                        if (cnt == ZW'(Z - 1)) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                assign fifo2_addr[i] = MAX_FIFO2_ADDR_BITS'(cnt);
            end
        end
    endgenerate

endmodule

// File: tb/tb_ntt_seq.sv
// tb/tb_ntt_seq.sv - Directed bench for ntt_seq with RAM and fixed-latency core models

module tb_ntt_seq;

    localparam int DW  = 12;
    localparam int NS  = 7;
    localparam int MB  = 2;
    localparam int FB  = 5;
    localparam int P   = 128;
    localparam int LAT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                     start, abort, busy, done, err;
    logic                     rd_en, ntt_in_en, ntt_out_en, wr_en;
    logic [NS-1:0]            rd_addr, wr_addr, fifo_en;
    logic [2*DW-1:0]          rd_data, wr_data;
    logic [1:0][DW-1:0]       ntt_in, ntt_out;
    logic [MB-1:0]            fifom_addr;
    logic [NS-1:0][FB-1:0]    fifo2_addr;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int core_limit = 1 << 30;
    int core_sent = 0;
    int q_due[$];
    logic [2*DW-1:0] q_dat[$];
    logic ram_pend = 1'b0;
    logic [NS-1:0] ram_addr = '0;

    ntt_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ntt_in_en(ntt_in_en), .ntt_in(ntt_in),
        .ntt_out_en(ntt_out_en), .ntt_out(ntt_out),
        .fifo_en(fifo_en), .fifom_addr(fifom_addr), .fifo2_addr(fifo2_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic [2*DW-1:0] mem_word(input int a);
        mem_word = {12'(a * 37 + 5), 12'(a ^ 'hABC)};
    endfunction

    function automatic logic [2*DW-1:0] core_fn(input logic [2*DW-1:0] v);
        core_fn = {v[23:12] ^ 12'h0F0, v[11:0] + 12'd1};
    endfunction

    // One clock of the RAM and core models; returns just after the falling edge.
    task automatic cycle();
        logic [2*DW-1:0] d;
        @(negedge clk);
        rd_data = ram_pend ? mem_word(int'(ram_addr)) : 24'($urandom);
        ram_pend = rd_en;
        ram_addr = rd_addr;
        #1;
        if (ntt_in_en) begin
            q_due.push_back(cyc + LAT);
            q_dat.push_back(core_fn(ntt_in));
        end
        ntt_out_en = 1'b0;
        ntt_out = 24'($urandom);
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            d = q_dat.pop_front();
            if (core_sent < core_limit) begin
                ntt_out_en = 1'b1;
                ntt_out = d;
                core_sent++;
            end
        end
        cyc++;
    endtask

    task automatic flush();
        q_due.delete();
        q_dat.delete();
        core_sent = 0;
        ram_pend = 1'b0;
        ntt_out_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        checks++; if ({busy, done, err, rd_en, ntt_in_en, wr_en} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, rd_en, ntt_in_en, wr_en}); end
        checks++; if (rd_addr !== '0 || wr_addr !== '0) begin failures++; $display("FAIL reset_addr rd=%0h wr=%0h exp=0", rd_addr, wr_addr); end
        checks++; if (fifom_addr !== '0 || fifo2_addr !== '0) begin failures++; $display("FAIL reset_fifo fm=%0h f2=%0h exp=0", fifom_addr, fifo2_addr); end
        checks++; if (ntt_in !== '0 || wr_data !== '0) begin failures++; $display("FAIL reset_data in=%0h wr=%0h exp=0", ntt_in, wr_data); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_fifom();
        fifo_en = 7'b0000001;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            checks++; if (fifom_addr !== 2'(k % 3)) begin failures++; $display("FAIL fifom_step%0d got=%0d exp=%0d", k, fifom_addr, k % 3); end
            checks++; if (fifo2_addr !== '0) begin failures++; $display("FAIL fifom_fifo2_zero%0d got=%0h exp=0", k, fifo2_addr); end
        end
        fifo_en = '0;
        cycle();
        checks++; if (fifom_addr !== 2'd1) begin failures++; $display("FAIL fifom_hold got=%0d exp=1", fifom_addr); end
    endtask

    task automatic test_fifo2();
        fifo_en = 7'b0000010;
        for (int k = 1; k <= 28; k++) begin
            cycle();
            checks++; if (fifo2_addr[1] !== 5'(k % 27)) begin failures++; $display("FAIL fifo2_s1_step%0d got=%0d exp=%0d", k, fifo2_addr[1], k % 27); end
        end
        fifo_en = 7'b0001000;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++; if (fifo2_addr[3] !== 5'(k % 3)) begin failures++; $display("FAIL fifo2_s3_step%0d got=%0d exp=%0d", k, fifo2_addr[3], k % 3); end
        end
        fifo_en = 7'b0010000;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++; if (fifo2_addr[4] !== 5'd0) begin failures++; $display("FAIL fifo2_s4_step%0d got=%0d exp=0", k, fifo2_addr[4]); end
        end
        fifo_en = 7'b1000000;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++; if (fifo2_addr[6] !== 5'(k % 2)) begin failures++; $display("FAIL fifo2_s6_step%0d got=%0d exp=%0d", k, fifo2_addr[6], k % 2); end
        end
        fifo_en = '0;
    endtask

    task automatic test_transform();
        int rd_n = 0, in_n = 0, wr_n = 0, done_n = 0, in_first = -1, in_last = -1;
        logic prev_wr = 1'b0;
        bit fin = 0;
        flush();
        start = 1'b1;
        for (int t = 0; t < 400 && !fin; t++) begin
            cycle();
            if (t == 0) begin
                start = 1'b0;
                checks++; if (rd_en !== 1'b1 || rd_addr !== '0) begin failures++; $display("FAIL xf_first_read en=%b addr=%0d exp en=1 addr=0", rd_en, rd_addr); end
            end
            if (rd_en) begin
                checks++; if (rd_addr !== 7'(rd_n)) begin failures++; $display("FAIL xf_rd_addr got=%0d exp=%0d", rd_addr, rd_n); end
                rd_n++;
            end
            if (ntt_in_en) begin
                checks++; if (ntt_in !== mem_word(in_n)) begin failures++; $display("FAIL xf_ntt_in%0d got=%0h exp=%0h", in_n, ntt_in, mem_word(in_n)); end
                if (in_first < 0) in_first = t;
                in_last = t;
                in_n++;
            end
            if (wr_en) begin
                checks++; if (wr_addr !== 7'(wr_n) || wr_data !== core_fn(mem_word(wr_n))) begin failures++; $display("FAIL xf_write%0d addr=%0d data=%0h exp addr=%0d data=%0h", wr_n, wr_addr, wr_data, wr_n, core_fn(mem_word(wr_n))); end
                wr_n++;
            end
            if (done) begin
                done_n++;
                fin = 1;
                checks++; if (prev_wr !== 1'b1 || wr_n != P) begin failures++; $display("FAIL xf_done_timing prev_wr=%b writes=%0d exp prev_wr=1 writes=%0d", prev_wr, wr_n, P); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL xf_busy_at_done got=%b exp=0", busy); end
            end else begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL xf_busy t=%0d got=%b exp=1", t, busy); end
            end
            prev_wr = wr_en;
        end
        checks++; if (rd_n != P || in_n != P) begin failures++; $display("FAIL xf_counts reads=%0d ins=%0d exp=%0d", rd_n, in_n, P); end
        checks++; if (in_last - in_first + 1 != P) begin failures++; $display("FAIL xf_contiguous span=%0d exp=%0d", in_last - in_first + 1, P); end
        checks++; if (done_n != 1) begin failures++; $display("FAIL xf_done_count got=%0d exp=1", done_n); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL xf_after done=%b busy=%b exp 0 0", done, busy); end
        end
    endtask

    task automatic test_timeout();
        int w100 = -1, err_t = -1, done_n = 0, wr_n = 0;
        flush();
        core_limit = 100;
        start = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            cycle();
            if (t == 0) start = 1'b0;
            if (wr_en) begin
                wr_n++;
                if (wr_addr == 7'd99) w100 = t;
            end
            if (done) done_n++;
            if (err) begin
                err_t = t;
                break;
            end
        end
        checks++; if (err_t < 0 || err_t - w100 != 1023) begin failures++; $display("FAIL to_latency got=%0d exp=1023 (err_t=%0d)", err_t - w100, err_t); end
        checks++; if (wr_n != 100) begin failures++; $display("FAIL to_beats got=%0d exp=100", wr_n); end
        checks++; if (busy !== 1'b0 || done_n != 0) begin failures++; $display("FAIL to_state busy=%b dones=%0d exp 0 0", busy, done_n); end
        cycle();
        checks++; if (err !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL to_after err=%b busy=%b rd_en=%b done=%b exp 0", err, busy, rd_en, done); end
        core_limit = 1 << 30;
        flush();
    endtask

    task automatic test_abort();
        int wr_first = -1;
        bit got_done = 0;
        flush();
        start = 1'b1;
        fifo_en = 7'b0000010;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
            if (k == 1) fifo_en = '0;
        end
        checks++; if (rd_addr !== 7'd9 || rd_en !== 1'b1) begin failures++; $display("FAIL ab_before addr=%0d en=%b exp addr=9 en=1", rd_addr, rd_en); end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0) begin failures++; $display("FAIL ab_idle busy=%b rd_en=%b addr=%0d exp 0 0 0", busy, rd_en, rd_addr); end
        checks++; if (fifom_addr !== '0 || fifo2_addr !== '0) begin failures++; $display("FAIL ab_fifo_clear fm=%0h f2=%0h exp=0", fifom_addr, fifo2_addr); end
        checks++; if (ntt_in_en !== 1'b1) begin failures++; $display("FAIL ab_pending_beat got=%b exp=1", ntt_in_en); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ab_no_pulse done=%b err=%b exp 0 0", done, err); end
        cycle();
        checks++; if (ntt_in_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL ab_quiet in_en=%b wr_en=%b exp 0 0", ntt_in_en, wr_en); end
        flush();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) begin failures++; $display("FAIL ab_restart en=%b addr=%0d busy=%b exp 1 0 1", rd_en, rd_addr, busy); end
        for (int t = 0; t < 400; t++) begin
            cycle();
            if (wr_en && wr_first < 0) wr_first = int'(wr_addr);
            if (done) begin
                got_done = 1;
                break;
            end
        end
        checks++; if (wr_first != 0 || !got_done) begin failures++; $display("FAIL ab_rerun first_wr=%0d done=%0d exp 0 1", wr_first, got_done); end
    endtask

    task automatic test_start_ignored();
        int done_n = 0, rd_n = 0;
        flush();
        start = 1'b1;
        for (int t = 0; t < 400; t++) begin
            cycle();
            start = (t == 149);
            if (rd_en) rd_n++;
            if (done) begin
                done_n++;
                break;
            end
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL si_done_cycle busy=%b rd_en=%b exp 0 0", busy, rd_en); end
        for (int t = 0; t < 60; t++) begin
            cycle();
            if (rd_en) rd_n++;
            if (done) done_n++;
        end
        checks++; if (done_n != 1 || rd_n != P) begin failures++; $display("FAIL si_counts dones=%0d reads=%0d exp 1 %0d", done_n, rd_n, P); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL si_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        int done_n = 0;
        flush();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, err, rd_en, ntt_in_en, wr_en} !== 6'b0) begin failures++; $display("FAIL ar_flags got=%b exp=000000", {busy, done, err, rd_en, ntt_in_en, wr_en}); end
        checks++; if (rd_addr !== '0 || ntt_in !== '0 || wr_addr !== '0) begin failures++; $display("FAIL ar_values addr=%0d in=%0h wr=%0d exp 0", rd_addr, ntt_in, wr_addr); end
        cycle();
        rst = 1'b0;
        flush();
        for (int t = 0; t < 200; t++) begin
            cycle();
            if (done) done_n++;
        end
        checks++; if (done_n != 0 || busy !== 1'b0) begin failures++; $display("FAIL ar_no_done dones=%0d busy=%b exp 0 0", done_n, busy); end
    endtask

    initial begin
        start = 1'b0;
        abort = 1'b0;
        fifo_en = '0;
        rd_data = '0;
        ntt_out_en = 1'b0;
        ntt_out = '0;
        test_reset();
        test_fifom();
        test_fifo2();
        test_transform();
        test_timeout();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
